// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Parity protection of stored words is enabled by defining INSTR_MEM_PARITY_EN.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    localparam logic [15:0] NOP_DEFAULT = 16'h0000;

    function automatic int unsigned bytes_per_instr(input int unsigned instr_wid);
        return instr_wid / 8;
    endfunction

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Fetch and byte-serial program-load signals of the instruction memory.
// master = fetch stage + loader side, slave = memory side.
interface instr_mem_loadable_if #(
    parameter int unsigned PROG_CTR_WID = 10,
    parameter int unsigned INSTR_WID    = 16
) ();
    logic                    fetch_en;
    logic [PROG_CTR_WID-1:0] prog_ctr;
    logic [INSTR_WID-1:0]    instr_out;
    logic                    instr_valid;
    logic                    parity_err;
    logic                    load_start;
    logic [PROG_CTR_WID-1:0] load_base;
    logic [PROG_CTR_WID:0]   load_len;
    logic [7:0]              ld_byte;
    logic                    ld_valid;
    logic                    ld_ready;
    logic                    load_busy;
    logic                    load_done;

    modport master (
        output fetch_en, prog_ctr, load_start, load_base, load_len, ld_byte, ld_valid,
        input  instr_out, instr_valid, parity_err, ld_ready, load_busy, load_done
    );

    modport slave (
        input  fetch_en, prog_ctr, load_start, load_base, load_len, ld_byte, ld_valid,
        output instr_out, instr_valid, parity_err, ld_ready, load_busy, load_done
    );
endinterface

// File: rtl/instr_mem_byte_assembler.sv
// Collects load bytes MSB-first into one instruction word.
// o_word_ready flags the cycle in which the last byte of a word is taken.
module instr_mem_byte_assembler
    import instr_mem_pkg::*;
#(
    parameter int unsigned INSTR_WID = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clr,
    input  logic                 i_take,
    input  logic [7:0]           i_byte,
    output logic [INSTR_WID-1:0] o_word,
    output logic                 o_word_ready
);
    localparam int unsigned BPI     = bytes_per_instr(INSTR_WID);
    localparam int unsigned CNT_WID = (BPI > 1) ? $clog2(BPI) : 1;
    localparam logic [CNT_WID-1:0] LAST_BYTE = CNT_WID'(BPI - 1);

    logic [INSTR_WID-1:0] r_shift;
    logic [CNT_WID-1:0]   r_byte_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_clr) begin
            r_byte_cnt <= '0;
        end else if (i_take) begin
            r_shift    <= (r_shift << 8) | INSTR_WID'(i_byte);
            r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + CNT_WID'(1);
        end
    end

    assign o_word       = r_shift;
    assign o_word_ready = i_take && (r_byte_cnt == LAST_BYTE);
endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory with registered fetch and a byte-serial runtime load port.
// Define INSTR_MEM_PARITY_EN to store an even-parity bit per word and flag mismatches on fetch.
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int unsigned           PROG_CTR_WID = 10,
    parameter int unsigned           INSTR_WID    = 16,
    parameter logic [INSTR_WID-1:0]  NOP_INSTR    = INSTR_WID'(NOP_DEFAULT)
) (
    input logic                  clk,
    input logic                  reset,
    instr_mem_loadable_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** PROG_CTR_WID;
`ifdef INSTR_MEM_PARITY_EN
    localparam int unsigned MEM_WID = INSTR_WID + 1;
`else
    localparam int unsigned MEM_WID = INSTR_WID;
`endif

    logic [MEM_WID-1:0]      r_mem [DEPTH];
    load_state_t             r_state;
    load_state_t             w_next;
    logic [PROG_CTR_WID-1:0] r_addr;
    logic [PROG_CTR_WID:0]   r_words_left;
    logic [INSTR_WID-1:0]    r_instr;
    logic                    r_valid;
    logic                    w_capture;
    logic                    w_take;
    logic                    w_commit;
    logic                    w_word_ready;
    logic [INSTR_WID-1:0]    w_word;
    logic [MEM_WID-1:0]      w_rd;
    logic [MEM_WID-1:0]      w_wr;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_take    = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.load_start) begin
                    w_capture = 1'b1;
                    w_next    = (bus.load_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_take = bus.ld_valid;
                if (w_word_ready) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_commit = 1'b1;
                w_next   = (r_words_left == (PROG_CTR_WID+1)'(1)) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: w_next = ST_RUN;
            default: w_next = ST_RUN;
        endcase
    end

    assign bus.ld_ready  = (r_state == ST_LOAD);
    assign bus.load_busy = (r_state != ST_RUN);
    assign bus.load_done = (r_state == ST_DONE);

    instr_mem_byte_assembler #(
        .INSTR_WID (INSTR_WID)
    ) u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (w_capture | w_commit),
        .i_take       (w_take),
        .i_byte       (bus.ld_byte),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_words_left <= '0;
        end else if (w_capture) begin
            r_addr       <= bus.load_base;
            r_words_left <= bus.load_len;
        end else if (w_commit) begin
            r_addr       <= r_addr + PROG_CTR_WID'(1);
            r_words_left <= r_words_left - (PROG_CTR_WID+1)'(1);
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    assign w_wr = {^w_word, w_word};
`else
    assign w_wr = w_word;
`endif

    // Contents are never reset; a reset landing on a WRITE cycle suppresses the commit.
    always_ff @(posedge clk) begin
        if (w_commit && !reset) r_mem[r_addr] <= w_wr;
    end

    assign w_rd = r_mem[bus.prog_ctr];

    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_RUN)) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (bus.fetch_en) begin
            r_instr <= w_rd[INSTR_WID-1:0];
            r_valid <= 1'b1;
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_RUN)) r_parity_err <= 1'b0;
        else if (bus.fetch_en)            r_parity_err <= w_rd[INSTR_WID] ^ (^w_rd[INSTR_WID-1:0]);
    end

    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.instr_out   = r_instr;
    assign bus.instr_valid = r_valid;
endmodule
